// File: rtl/mioc_reset_seq.sv
// MIOC reset front-end: synchronises and debounces PBRST_N/N_CVRST and drives stretched RST_N, CPRST_N, NETRST_N and GAME_MODE.
// Optional macro MIOC_NETRST_EXTEND_EN holds NETRST_N low NET_HOLD extra cycles via a NETX state.
module mioc_reset_seq #(
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned STRETCH_CYCLES = 64,
  parameter int unsigned NET_HOLD       = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic B_PHI,
  input  logic POR_N,
  input  logic PBRST_N,
  input  logic N_CVRST,
  output logic RST_N,
  output logic CPRST_N,
  output logic NETRST_N,
  output logic GAME_MODE
);

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_DEB,
    ST_HOLD,
    ST_STRETCH,
    ST_NETX
  } state_t;

  // The IDLE cycle that first sees a press counts toward the press debounce,
  // so DEB terminates one count earlier than the release debounce in HOLD.
  localparam logic [CNT_W-1:0] DEB_PRESS_TC = CNT_W'(DEB_CYCLES - 2);
  localparam logic [CNT_W-1:0] DEB_REL_TC   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_TC   = CNT_W'(STRETCH_CYCLES - 1);
`ifdef MIOC_NETRST_EXTEND_EN
  localparam logic [CNT_W-1:0] NET_TC       = CNT_W'(NET_HOLD - 1);
  localparam state_t           ST_RELEASE   = ST_NETX;
`else
  localparam state_t           ST_RELEASE   = ST_IDLE;
`endif

  logic pb_q1, pb_s, cv_q1, cv_s;
  logic any_low;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gm_q, gm_d;
  logic             rst_n_q, cprst_n_q, netrst_n_q;
  logic             rst_n_d, cprst_n_d, netrst_n_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge B_PHI or negedge POR_N) begin
    if (!POR_N) begin
      pb_q1 <= 1'b1;
      pb_s  <= 1'b1;
      cv_q1 <= 1'b1;
      cv_s  <= 1'b1;
    end else begin
      pb_q1 <= PBRST_N;
      pb_s  <= pb_q1;
      cv_q1 <= N_CVRST;
      cv_s  <= cv_q1;
    end
  end

  assign any_low = !pb_s || !cv_s;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gm_d    = gm_q;
    unique case (state_q)
      ST_POR: begin
        if (cnt_q == STRETCH_TC) begin
          cnt_d = '0;
          if (any_low) begin
            state_d = ST_HOLD;
            gm_d    = pb_s;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (any_low) begin
          state_d = ST_DEB;
          cnt_d   = '0;
        end
      end
      ST_DEB: begin
        if (!any_low) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_PRESS_TC) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          gm_d    = pb_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!pb_s) gm_d = 1'b0;
        if (any_low) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_REL_TC) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STRETCH: begin
        if (any_low) begin
          // Still inside one reset pulse: a game press must not lift CPRST_N mid-reset.
          state_d = ST_HOLD;
          cnt_d   = '0;
          gm_d    = gm_q && pb_s;
        end else if (cnt_q == STRETCH_TC) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MIOC_NETRST_EXTEND_EN
      ST_NETX: begin
        if (any_low) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          gm_d    = pb_s;
        end else if (cnt_q == NET_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on the transition edge.
  always_comb begin
    netrst_n_d = (state_d == ST_IDLE) || (state_d == ST_DEB);
    rst_n_d    = netrst_n_d || (state_d == ST_NETX);
    cprst_n_d  = rst_n_d || (gm_d && ((state_d == ST_HOLD) || (state_d == ST_STRETCH)));
  end

  always_ff @(posedge B_PHI or negedge POR_N) begin
    if (!POR_N) begin
      state_q    <= ST_POR;
      cnt_q      <= '0;
      gm_q       <= 1'b0;
      rst_n_q    <= 1'b0;
      cprst_n_q  <= 1'b0;
      netrst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gm_q       <= gm_d;
      rst_n_q    <= rst_n_d;
      cprst_n_q  <= cprst_n_d;
      netrst_n_q <= netrst_n_d;
    end
  end

  assign RST_N     = rst_n_q;
  assign CPRST_N   = cprst_n_q;
  assign NETRST_N  = netrst_n_q;
  assign GAME_MODE = gm_q;

endmodule

// File: tb/tb_mioc_reset_seq.sv
// Directed testbench for mioc_reset_seq with DEB_CYCLES=4, STRETCH_CYCLES=8, NET_HOLD=6.
// Observed vector is {RST_N, CPRST_N, NETRST_N, GAME_MODE}; inputs change and outputs are sampled on negedges.
module tb_mioc_reset_seq;

`ifdef MIOC_NETRST_EXTEND_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam int NX = 6;

  logic clk;
  logic por_n, pbrst_n, n_cvrst;
  logic rst_n, cprst_n, netrst_n, game_mode;
  logic [3:0] obs;
  logic [3:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  assign obs = {rst_n, cprst_n, netrst_n, game_mode};

  mioc_reset_seq #(
    .DEB_CYCLES    (4),
    .STRETCH_CYCLES(8),
    .NET_HOLD      (6),
    .CNT_W         (16)
  ) dut (
    .B_PHI    (clk),
    .POR_N    (por_n),
    .PBRST_N  (pbrst_n),
    .N_CVRST  (n_cvrst),
    .RST_N    (rst_n),
    .CPRST_N  (cprst_n),
    .NETRST_N (netrst_n),
    .GAME_MODE(game_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL por_held obs=%b exp=0000", obs);
    end
    por_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_v = (i < 8) ? 4'b0000 : {1'b1, 1'b1, !EXT, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL por_release cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    if (EXT) begin
      for (int i = 1; i <= NX; i++) begin
        @(negedge clk);
        exp_v = (i < NX) ? 4'b1100 : 4'b1110;
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL por_netx cyc=%0d obs=%b exp=%b", i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_glitch();
    n_cvrst = 1'b0;
    repeat (2) @(negedge clk);
    n_cvrst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 4'b1110) begin
        n_bad++;
        $display("FAIL glitch cyc=%0d obs=%b exp=1110", i, obs);
      end
    end
  endtask

  task automatic test_game_reset();
    n_cvrst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_v = (i < 6) ? 4'b1110 : 4'b0101;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL game_press cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    n_cvrst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_v = (i < 14) ? 4'b0101 : {1'b1, 1'b1, !EXT, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL game_release cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    if (EXT) begin
      for (int i = 1; i <= NX; i++) begin
        @(negedge clk);
        exp_v = (i < NX) ? 4'b1101 : 4'b1111;
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL game_netx cyc=%0d obs=%b exp=%b", i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    pbrst_n = 1'b0;
    n_cvrst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_v = (i < 6) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL both_press cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    pbrst_n = 1'b1;
    n_cvrst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_v = (i < 14) ? 4'b0000 : {1'b1, 1'b1, !EXT, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL both_release cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    if (EXT) begin
      for (int i = 1; i <= NX; i++) begin
        @(negedge clk);
        exp_v = (i < NX) ? 4'b1100 : 4'b1110;
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL both_netx cyc=%0d obs=%b exp=%b", i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_repress();
    pbrst_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_v = (i < 6) ? 4'b1110 : 4'b0000;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL repress_first cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    pbrst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_bad++;
        $display("FAIL repress_stretch cyc=%0d obs=%b exp=0000", i, obs);
      end
    end
    pbrst_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_bad++;
        $display("FAIL repress_second cyc=%0d obs=%b exp=0000", i, obs);
      end
    end
    pbrst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_v = (i < 14) ? 4'b0000 : {1'b1, 1'b1, !EXT, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL repress_release cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    if (EXT) repeat (NX) @(negedge clk);
  endtask

  task automatic test_por_mid_hold();
    n_cvrst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_v = (i < 6) ? 4'b1110 : 4'b0101;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL por_hold_press cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    #2 por_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL por_async obs=%b exp=0000", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL por_async_held obs=%b exp=0000", obs);
    end
    n_cvrst = 1'b1;
    por_n   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_v = (i < 8) ? 4'b0000 : {1'b1, 1'b1, !EXT, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL por_repeat cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    if (EXT) begin
      for (int i = 1; i <= NX; i++) begin
        @(negedge clk);
        exp_v = (i < NX) ? 4'b1100 : 4'b1110;
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL por_repeat_netx cyc=%0d obs=%b exp=%b", i, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    por_n   = 1'b0;
    pbrst_n = 1'b1;
    n_cvrst = 1'b1;
    test_reset();
    test_glitch();
    test_game_reset();
    test_simultaneous();
    test_repress();
    test_por_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
